// File: rtl/ao_sched_pkg.sv
// Shared types and helpers for the AND-OR frame scheduler.
package ao_sched_pkg;

  localparam int NUM_REQ = 3;
  localparam int GROUP_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    RESULT  = 1'b1
  } state_t;

  // One-hot grant: first eligible requester scanning ptr, ptr+1, ptr+2 (mod NUM_REQ).
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] eligible,
                                                 input logic [1:0]         ptr);
    logic [NUM_REQ-1:0] g;
    int idx;
    g = '0;
    // Scan from the farthest candidate back so the nearest eligible one wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (eligible[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ao_term.sv
// Shared AND-OR term evaluator: n = (i1 & i2) | (i3 & i4).
module ao_term (
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  output logic n
);

  assign n = (i1 & i2) | (i3 & i4);

endmodule

// File: rtl/ao_frame_scheduler.sv
// Round-robin scheduler sharing one AND-OR term evaluator among three
// requesters; collects a three-term frame, then presents
// y = (w0&w1)|(w1&w2) on a valid/ready output. Stale partial frames are
// aborted after TIMEOUT cycles (0 disables the timeout).
// Optional build macro AO_SCHED_STATS_EN adds frame_cnt/abort_cnt counters.
module ao_frame_scheduler
  import ao_sched_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*GROUP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic                       out_y,
  output logic [NUM_REQ-1:0]         out_w,
  input  logic                       out_ready,
  output logic                       timeout_err,
  output logic                       busy
`ifdef AO_SCHED_STATS_EN
  ,
  output logic [7:0]                 frame_cnt,
  output logic [7:0]                 abort_cnt
`endif
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   w_q, w_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_y_q, out_y_d;
  logic [NUM_REQ-1:0]   out_w_q, out_w_d;

  logic [NUM_REQ-1:0]   grant;
  logic                 tmo;
  logic                 fire;
  logic [GROUP_W-1:0]   sel_grp;
  logic                 term_n;

  // Timeout only applies to a partial frame being collected; the done_q
  // qualifier keeps a stale timer value from firing right after a handshake.
  assign tmo  = (TIMEOUT != 0) && (state_q == COLLECT) && (done_q != '0) && (tmr_q == TMR_MAX);
  assign fire = out_valid_q & out_ready;

  // Grant selection: no grants in RESULT or in the abort cycle.
  always_comb begin
    grant = '0;
    if (state_q == COLLECT && !tmo)
      grant = rr_pick(req_valid & ~done_q, rr_ptr_q);
  end

  // Route the granted group into the shared evaluator.
  always_comb begin
    sel_grp = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) sel_grp = req_data[i*GROUP_W +: GROUP_W];
  end

  ao_term u_term (
    .i1 (sel_grp[0]),
    .i2 (sel_grp[1]),
    .i3 (sel_grp[2]),
    .i4 (sel_grp[3]),
    .n  (term_n)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // FSM next state: complete frame enters RESULT, output handshake returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if ((grant != '0) && ((done_q | grant) == {NUM_REQ{1'b1}})) state_d = RESULT;
      RESULT:  if (fire) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs; ready is also masked while reset is asserted.
  always_comb begin
    req_ready   = grant & {NUM_REQ{~rst}};
    timeout_err = tmo;
    busy        = (done_q != '0) || (state_q == RESULT);
    out_valid   = out_valid_q;
    out_y       = out_y_q;
    out_w       = out_w_q;
  end

  // Frame datapath: term capture, done mask, round-robin pointer, timer, result.
  always_comb begin
    done_d      = done_q;
    w_d         = w_q;
    rr_ptr_d    = rr_ptr_q;
    tmr_d       = tmr_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_w_d     = out_w_q;

    if (state_q == RESULT) begin
      if (fire) begin
        done_d      = '0;
        out_valid_d = 1'b0;
      end
    end else if (tmo) begin
      done_d = '0;
    end else if (grant != '0) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i]) begin
          w_d[i]   = term_n;
          rr_ptr_d = (i == NUM_REQ - 1) ? 2'd0 : 2'(i + 1);
        end
      done_d = done_q | grant;
      if (done_d == {NUM_REQ{1'b1}}) begin
        out_valid_d = 1'b1;
        out_w_d     = w_d;
        out_y_d     = (w_d[0] & w_d[1]) | (w_d[1] & w_d[2]);
      end
    end

    // Age counts from the cycle after the first accepted group, saturating.
    if (done_q == '0 || tmo)
      tmr_d = '0;
    else if (state_q == COLLECT && tmr_q != TMR_MAX)
      tmr_d = tmr_q + TMR_W'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= '0;
      w_q         <= '0;
      rr_ptr_q    <= '0;
      tmr_q       <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= 1'b0;
      out_w_q     <= '0;
    end else begin
      done_q      <= done_d;
      w_q         <= w_d;
      rr_ptr_q    <= rr_ptr_d;
      tmr_q       <= tmr_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_w_q     <= out_w_d;
    end
  end

`ifdef AO_SCHED_STATS_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] abort_cnt_q, abort_cnt_d;

  // Wrapping event counters for delivered and aborted frames.
  always_comb begin
    frame_cnt_d = frame_cnt_q + {7'd0, fire};
    abort_cnt_d = abort_cnt_q + {7'd0, tmo};
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule
